proc_key_debounce: RTL and testbench

PROC_KEY_DEBOUNCE -- requirements
Module: proc_key_debounce

---
 rtl/proc_key_debounce.sv | 170 +++++++++++++++++
 tb/tb_proc_key_debounce.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_key_debounce.sv
// proc_key_debounce: WIDTH-channel key debouncer with an Avalon-MM register
// file and a level interrupt. Each raw key input goes through a 2-flop
// synchronizer. A per-channel counter then accepts a new level only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement with the current level.
// Accepted edges can be latched into a W1C capture register that feeds irq.
module proc_key_debounce #(
    parameter int WIDTH           = 20,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ADDR_STABLE   = 3'd0,
        ADDR_SYNC     = 3'd1,
        ADDR_IRQ_MASK = 3'd2,
        ADDR_EDGE_CAP = 3'd3,
        ADDR_RISE_EN  = 3'd4,
        ADDR_FALL_EN  = 3'd5,
        ADDR_EVT_CNT  = 3'd6,
        ADDR_RSVD     = 3'd7
    } addr_e;

    // Synchronizer and debounce state
    logic [WIDTH-1:0]            meta_q, meta_d;
    logic [WIDTH-1:0]            sync_q, sync_d;
    logic [WIDTH-1:0]            stable_q, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Register file
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [15:0]      event_count_q, event_count_d;
    logic [31:0]      readdata_q, readdata_d;

    // Per-cycle events and bus decode
    logic [WIDTH-1:0] rise_ev, fall_ev, set_ev;
    logic [WIDTH-1:0] wr_bits, clr_bits;
    logic             wr_en;
    addr_e            addr;

    // Bits of writedata above WIDTH are deliberately ignored.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata};

    assign addr    = addr_e'(address);
    assign wr_en   = chipselect & ~write_n;
    assign wr_bits = writedata[WIDTH-1:0];

    // Two-flop synchronizer: the debouncer only ever looks at sync_q.
    always_comb begin
        meta_d = in_port;
        sync_d = meta_q;
    end

    // Debounce: count consecutive mismatch cycles, commit on the last one.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_ev  = '0;
        fall_ev  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync_q[i];
                cnt_d[i]    = '0;
                rise_ev[i]  = sync_q[i];
                fall_ev[i]  = ~sync_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Register writes, capture set/clear and the saturating event counter.
    always_comb begin
        irq_mask_d    = irq_mask_q;
        rise_en_d     = rise_en_q;
        fall_en_d     = fall_en_q;
        event_count_d = event_count_q;
        clr_bits      = '0;
        set_ev        = (rise_ev & rise_en_q) | (fall_ev & fall_en_q);

        if (wr_en) begin
            case (addr)
                ADDR_IRQ_MASK: irq_mask_d = wr_bits;
                ADDR_EDGE_CAP: clr_bits   = wr_bits;
                ADDR_RISE_EN:  rise_en_d  = wr_bits;
                ADDR_FALL_EN:  fall_en_d  = wr_bits;
                default:       ;
            endcase
        end

        // A new event on a bit beats a same-cycle W1C clear of that bit.
        edge_capture_d = (edge_capture_q & ~clr_bits) | set_ev;

        if (|set_ev) begin
            if (wr_en && addr == ADDR_EVT_CNT) begin
                event_count_d = 16'd1;
            end else if (event_count_q != 16'hFFFF) begin
                event_count_d = event_count_q + 16'd1;
            end
        end else if (wr_en && addr == ADDR_EVT_CNT) begin
            event_count_d = 16'd0;
        end
    end

    // Read mux, registered every cycle regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (addr)
            ADDR_STABLE:   readdata_d[WIDTH-1:0] = stable_q;
            ADDR_SYNC:     readdata_d[WIDTH-1:0] = sync_q;
            ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_capture_q;
            ADDR_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
            ADDR_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
            ADDR_EVT_CNT:  readdata_d[15:0]      = event_count_q;
            ADDR_RSVD:     readdata_d            = '0;
            default:       readdata_d            = '0;
        endcase
    end

    // State registers; reset also aborts any debounce in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q         <= '0;
            sync_q         <= '0;
            stable_q       <= '0;
            cnt_q          <= '0;
            irq_mask_q     <= '0;
            edge_capture_q <= '0;
            rise_en_q      <= '1;
            fall_en_q      <= '0;
            event_count_q  <= '0;
            readdata_q     <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            meta_q         <= meta_d;
            sync_q         <= sync_d;
            stable_q       <= stable_d;
            cnt_q          <= cnt_d;
            irq_mask_q     <= irq_mask_d;
            edge_capture_q <= edge_capture_d;
            rise_en_q      <= rise_en_d;
            fall_en_q      <= fall_en_d;
            event_count_q  <= event_count_d;
            readdata_q     <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_proc_key_debounce.sv
// Self-checking bench for proc_key_debounce (WIDTH=20, DEBOUNCE_CYCLES=4).
// Directed scenarios use hand-derived constants; a random phase compares
// every cycle against a reference model that accepts a level once the last
// N synchronized samples all disagree with the accepted level.
`timescale 1ns/1ps
module tb_proc_key_debounce;

    localparam int W = 20;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   address = 3'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = 32'd0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  readdata;
    logic         irq;

    int n_tests = 0;
    int n_fail  = 0;

    proc_key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_meta, m_sync, m_stable, m_mask, m_cap, m_rise, m_fall;
    logic [W-1:0] m_win [N-1];   // previous N-1 synchronized samples, newest first
    logic [15:0]  m_cnt;
    logic [31:0]  m_rd;
    logic [W-1:0] mv_commit, mv_ev, mv_clr;
    logic         mv_wr;
    logic [31:0]  mv_rd;

    always_comb begin
        mv_commit = m_sync ^ m_stable;
        for (int k = 0; k < N-1; k++) mv_commit &= m_win[k] ^ m_stable;
        mv_ev  = (mv_commit & m_sync & m_rise) | (mv_commit & ~m_sync & m_fall);
        mv_wr  = chipselect && !write_n;
        mv_clr = (mv_wr && address == 3'd3) ? writedata[W-1:0] : '0;
        case (address)
            3'd0:    mv_rd = 32'(m_stable);
            3'd1:    mv_rd = 32'(m_sync);
            3'd2:    mv_rd = 32'(m_mask);
            3'd3:    mv_rd = 32'(m_cap);
            3'd4:    mv_rd = 32'(m_rise);
            3'd5:    mv_rd = 32'(m_fall);
            3'd6:    mv_rd = 32'(m_cnt);
            default: mv_rd = 32'd0;
        endcase
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_meta <= '0; m_sync <= '0; m_stable <= '0; m_mask <= '0;
            m_cap <= '0; m_rise <= '1; m_fall <= '0; m_cnt <= '0; m_rd <= '0;
            for (int k = 0; k < N-1; k++) m_win[k] <= '0;
        end else begin
            m_meta   <= in_port;
            m_sync   <= m_meta;
            m_stable <= m_stable ^ mv_commit;
            if (N > 1) m_win[0] <= m_sync;
            for (int k = 1; k < N-1; k++) m_win[k] <= m_win[k-1];
            m_cap <= (m_cap & ~mv_clr) | mv_ev;
            m_rd  <= mv_rd;
            if (|mv_ev)
                m_cnt <= (mv_wr && address == 3'd6) ? 16'd1 :
                         (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
            else if (mv_wr && address == 3'd6)
                m_cnt <= 16'd0;
            if (mv_wr && address == 3'd2) m_mask <= writedata[W-1:0];
            if (mv_wr && address == 3'd4) m_rise <= writedata[W-1:0];
            if (mv_wr && address == 3'd5) m_fall <= writedata[W-1:0];
        end
    end

    // ---------------- bus helpers (called at a falling edge) ----------------
    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] d, exp;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: readdata=%h irq=%b want 0/0", readdata, irq);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            exp = (a == 4) ? 32'h000F_FFFF : 32'd0;
            n_tests++;
            if (d !== exp) begin
                n_fail++; $display("FAIL reset_addr%0d: got %h want %h", a, d, exp);
            end
        end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    endtask

    task automatic test_basic_rise();
        logic [31:0] d;
        address = 3'd1; in_port[0] = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL sync_early: got %h want 0", readdata); end
        @(negedge clk);
        n_tests++;
        if (readdata !== 32'd1) begin n_fail++; $display("FAIL sync_bit0: got %h want 1", readdata); end
        address = 3'd0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL stable_early: got %h want 0", readdata); end
        @(negedge clk);
        n_tests++;
        if (readdata !== 32'd1) begin n_fail++; $display("FAIL stable_commit: got %h want 1", readdata); end
        rd(3'd3, d);
        n_tests++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL rise_capture: got %h want 1", d); end
        rd(3'd6, d);
        n_tests++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL rise_count: got %h want 1", d); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked: got %b want 0", irq); end
        wr(3'd2, 32'd1);
        n_tests++;
        if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_unmasked: got %b want 1", irq); end
        wr(3'd3, 32'd1);
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c: got %b want 0", irq); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        in_port[3] = 1'b1;
        repeat (3) @(negedge clk);
        in_port[3] = 1'b0;
        repeat (10) @(negedge clk);
        rd(3'd0, d);
        n_tests++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL glitch_stable: got %h want 1", d); end
        rd(3'd3, d);
        n_tests++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL glitch_capture: got %h want 0", d); end
        rd(3'd6, d);
        n_tests++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL glitch_count: got %h want 1", d); end
    endtask

    task automatic test_fall_enable();
        logic [31:0] d;
        in_port[5] = 1'b1;
        repeat (8) @(negedge clk);
        rd(3'd3, d);
        n_tests++;
        if (d !== 32'h20) begin n_fail++; $display("FAIL fe_rise_cap: got %h want 20", d); end
        in_port[5] = 1'b0;
        repeat (8) @(negedge clk);
        rd(3'd0, d);
        n_tests++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL fe_stable_low: got %h want 1", d); end
        rd(3'd6, d);
        n_tests++;
        if (d !== 32'd2) begin n_fail++; $display("FAIL fe_fall_ignored: count %h want 2", d); end
        wr(3'd3, 32'h20);
        wr(3'd5, 32'h20);
        in_port[5] = 1'b1;
        repeat (8) @(negedge clk);
        wr(3'd3, 32'h20);
        in_port[5] = 1'b0;
        repeat (8) @(negedge clk);
        rd(3'd3, d);
        n_tests++;
        if (d !== 32'h20) begin n_fail++; $display("FAIL fe_fall_cap: got %h want 20", d); end
        rd(3'd6, d);
        n_tests++;
        if (d !== 32'd4) begin n_fail++; $display("FAIL fe_count: got %h want 4", d); end
        wr(3'd3, 32'h20);
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        wr(3'd5, 32'h21);
        in_port[0] = 1'b0;
        repeat (8) @(negedge clk);
        rd(3'd3, d);
        n_tests++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL col_bit0: got %h want 1", d); end
        in_port[1] = 1'b1;
        repeat (5) @(negedge clk);
        address = 3'd3; writedata = 32'h3; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        rd(3'd3, d);
        n_tests++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL col_set_wins: got %h want 2", d); end
        rd(3'd6, d);
        n_tests++;
        if (d !== 32'd6) begin n_fail++; $display("FAIL col_count: got %h want 6", d); end
        n_tests++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL col_irq: got %b want 0", irq); end
    endtask

    task automatic test_reset_mid_debounce();
        logic [31:0] d;
        address = 3'd0; in_port[7] = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: readdata=%h irq=%b want 0/0", readdata, irq);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL mid_early: got %h want 0", readdata); end
        @(negedge clk);
        n_tests++;
        if (readdata !== 32'h82) begin n_fail++; $display("FAIL mid_commit: got %h want 82", readdata); end
        rd(3'd3, d);
        n_tests++;
        if (d !== 32'h82) begin n_fail++; $display("FAIL mid_capture: got %h want 82", d); end
        rd(3'd6, d);
        n_tests++;
        if (d !== 32'd1) begin n_fail++; $display("FAIL mid_count: got %h want 1", d); end
        rd(3'd5, d);
        n_tests++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL mid_fall_en: got %h want 0", d); end
    endtask

    task automatic test_random();
        int k;
        for (int c = 0; c < 3000; c++) begin
            n_tests++;
            if (readdata !== m_rd) begin
                n_fail++; $display("FAIL rand_readdata cycle %0d: got %h want %h", c, readdata, m_rd);
            end
            n_tests++;
            if (irq !== |(m_cap & m_mask)) begin
                n_fail++; $display("FAIL rand_irq cycle %0d: got %b want %b", c, irq, |(m_cap & m_mask));
            end
            reset_n    = (c == 1500) ? 1'b0 : 1'b1;
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, 3);
                in_port[k] = ~in_port[k];
            end
            if ($urandom_range(0, 9) == 0) begin
                k = $urandom_range(4, W-1);
                in_port[k] = ~in_port[k];
            end
            @(negedge clk);
        end
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic_rise();
        test_glitch();
        test_fall_enable();
        test_w1c_collision();
        test_reset_mid_debounce();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
